// File: rtl/alu_issue.sv
// alu_issue: requester-side sequencer for the combinational alu block.
//
// Accepts one operation at a time from decode. It drives the operands and
// then parks alu_func at IDLE_FUNC for one cycle (PRIME), so the ALU always
// sees a func change, even for identical back-to-back operations. It then
// issues the requested func and waits SETTLE_CYCLES cycles. Finally it
// captures the ALU result and flags, and holds them on the response channel
// until they are consumed.
//
// Parameters:
//   SETTLE_CYCLES  cycles the requested func is held before capture (1..15)
//   IDLE_FUNC      func code driven while not executing (not a real ALU op)
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   req_valid/req_ready             request handshake
//   req_op1/req_op2/req_func        operation from decode
//   alu_op1/alu_op2/alu_func        registered drive to the ALU
//   alu_result, alu_overflow,
//   alu_equals, alu_above, alu_zero ALU outputs
//   rsp_valid/rsp_ready             response handshake
//   rsp_result, rsp_flags           captured result, {ovf, eq, above, zero}
//   rsp_err                         operation was not executed
//   busy                            sequencer not idle
//
// Build option:
//   ALU_ISSUE_DIV0_TRAP_EN  when defined, a divide with alu_op2 == 0 is not
//                           issued. It returns rsp_err=1 with the overflow
//                           flag set instead.
module alu_issue #(
   parameter int unsigned SETTLE_CYCLES = 1,
   parameter logic [2:0]  IDLE_FUNC     = 3'b111
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_op1,
   input  logic [31:0] req_op2,
   input  logic [2:0]  req_func,
   output logic [31:0] alu_op1,
   output logic [31:0] alu_op2,
   output logic [2:0]  alu_func,
   input  logic [31:0] alu_result,
   input  logic        alu_overflow,
   input  logic        alu_equals,
   input  logic        alu_above,
   input  logic        alu_zero,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_result,
   output logic [3:0]  rsp_flags,
   output logic        rsp_err,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRIME = 2'd1,
      EXEC  = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [2:0]  func_q;
   logic [3:0]  count;
   logic        illegal;
   logic        div0;
   logic        reject;
   logic        rsp_take;

   assign illegal  = (func_q == 3'b111);
`ifdef ALU_ISSUE_DIV0_TRAP_EN
   assign div0     = (func_q == 3'b011) && (alu_op2 == '0);
`else
   assign div0     = 1'b0;
`endif
   assign reject   = illegal || div0;
   assign rsp_take = rsp_valid && rsp_ready;

   assign req_ready = (state == IDLE);
   assign busy      = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (req_valid)     state_nxt = PRIME;
         PRIME:   state_nxt = reject ? DONE : EXEC;
         EXEC:    if (count == '0)   state_nxt = DONE;
         DONE:    if (rsp_take)      state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_op1    <= '0;
         alu_op2    <= '0;
         alu_func   <= IDLE_FUNC;
         func_q     <= '0;
         count      <= '0;
         rsp_valid  <= 1'b0;
         rsp_result <= '0;
         rsp_flags  <= '0;
         rsp_err    <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (req_valid) begin
                  alu_op1 <= req_op1;
                  alu_op2 <= req_op2;
                  func_q  <= req_func;
               end
            end
            PRIME: begin
               if (reject) begin
                  // Not issued: alu_func stays at IDLE_FUNC.
                  rsp_result <= '0;
                  rsp_flags  <= div0 ? 4'b1000 : 4'b0000;
                  rsp_err    <= 1'b1;
                  rsp_valid  <= 1'b1;
               end else begin
                  alu_func <= func_q;
                  count    <= 4'(SETTLE_CYCLES - 1);
               end
            end
            EXEC: begin
               if (count != '0) begin
                  count <= count - 4'd1;
               end else begin
                  rsp_result <= alu_result;
                  rsp_flags  <= {alu_overflow, alu_equals, alu_above, alu_zero};
                  rsp_err    <= 1'b0;
                  rsp_valid  <= 1'b1;
                  alu_func   <= IDLE_FUNC;
               end
            end
            DONE: begin
               if (rsp_take) rsp_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_issue.sv
module tb_alu_issue;

   logic        clk;
   int          pass_cnt;
   int          total_cnt;

   // DUT with SETTLE_CYCLES=1
   logic        rst_n, req_valid, req_ready, rsp_valid, rsp_ready, rsp_err, busy;
   logic [31:0] req_op1, req_op2, alu_op1, alu_op2, alu_result, rsp_result;
   logic [2:0]  req_func, alu_func;
   logic        alu_overflow, alu_equals, alu_above, alu_zero;
   logic [3:0]  rsp_flags;

   // DUT with SETTLE_CYCLES=4
   logic        rst4_n, req_valid4, req_ready4, rsp_valid4, rsp_ready4, rsp_err4, busy4;
   logic [31:0] req_op1_4, req_op2_4, alu_op1_4, alu_op2_4, alu_result4, rsp_result4;
   logic [2:0]  req_func4, alu_func4;
   logic        alu_overflow4, alu_equals4, alu_above4, alu_zero4;
   logic [3:0]  rsp_flags4;

   // Behavioural ALU: {result, overflow, equals, above, zero}
   function automatic logic [35:0] alu_model(logic [31:0] a, logic [31:0] b, logic [2:0] f);
      logic [31:0] r;
      logic        ov;
      ov = 1'b0;
      case (f)
         3'b000: begin r = a + b; ov = (a[31] == b[31]) && (r[31] != a[31]); end
         3'b001: begin r = a - b; ov = (a[31] != b[31]) && (r[31] != a[31]); end
         3'b010: r = a * b;
         3'b011: begin
            if (b == 32'd0) begin r = 32'd0; ov = 1'b1; end
            else r = $signed(a) / $signed(b);
         end
         3'b100: r = a & b;
         3'b101: r = a | b;
         3'b110: r = ~a;
         default: r = 32'hDEADBEEF;
      endcase
      return {r, ov, a == b, $signed(a) > $signed(b), r == 32'd0};
   endfunction

   assign {alu_result, alu_overflow, alu_equals, alu_above, alu_zero} =
      alu_model(alu_op1, alu_op2, alu_func);
   assign {alu_result4, alu_overflow4, alu_equals4, alu_above4, alu_zero4} =
      alu_model(alu_op1_4, alu_op2_4, alu_func4);

   alu_issue #(.SETTLE_CYCLES(1), .IDLE_FUNC(3'b111)) u1 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_op1(req_op1), .req_op2(req_op2), .req_func(req_func),
      .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_func(alu_func),
      .alu_result(alu_result), .alu_overflow(alu_overflow), .alu_equals(alu_equals),
      .alu_above(alu_above), .alu_zero(alu_zero),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
      .rsp_flags(rsp_flags), .rsp_err(rsp_err), .busy(busy)
   );

   alu_issue #(.SETTLE_CYCLES(4), .IDLE_FUNC(3'b111)) u4 (
      .clk(clk), .rst_n(rst4_n), .req_valid(req_valid4), .req_ready(req_ready4),
      .req_op1(req_op1_4), .req_op2(req_op2_4), .req_func(req_func4),
      .alu_op1(alu_op1_4), .alu_op2(alu_op2_4), .alu_func(alu_func4),
      .alu_result(alu_result4), .alu_overflow(alu_overflow4), .alu_equals(alu_equals4),
      .alu_above(alu_above4), .alu_zero(alu_zero4),
      .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready4), .rsp_result(rsp_result4),
      .rsp_flags(rsp_flags4), .rsp_err(rsp_err4), .busy(busy4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   typedef struct {
      logic [31:0] op1;
      logic [31:0] op2;
      logic [2:0]  func;
      logic [31:0] res;
      logic [3:0]  flags;
      logic        err;
      int          lat;   // rising edges from accept edge to rsp_valid
      int          hold;  // cycles rsp_ready is held low once rsp_valid is up
   } vec_t;

   vec_t vecs[11];

   task automatic run_vec(input vec_t v, input int idx);
      int lat;
      int bad;
      int hold_bad;
      string tag;
      tag = $sformatf("v%0d", idx);
      @(negedge clk);
      check({tag, "_req_ready"}, req_ready, 1);
      req_valid = 1'b1;
      req_op1   = v.op1;
      req_op2   = v.op2;
      req_func  = v.func;
      rsp_ready = (v.hold == 0);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      req_op1   = $urandom;
      req_op2   = $urandom;
      req_func  = 3'($urandom);
      lat = 0;
      bad = 0;
      if (alu_func !== 3'b111) bad++;        // PRIME keeps the idle code
      while (rsp_valid !== 1'b1 && lat < 40) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (rsp_valid !== 1'b1) begin
            if (alu_func !== (v.err ? 3'b111 : v.func)) bad++;
         end
      end
      if (alu_func !== 3'b111) bad++;        // back to idle once captured
      check({tag, "_latency"}, lat, v.lat);
      check({tag, "_func_seq_bad"}, bad, 0);
      check({tag, "_result"}, rsp_result, v.res);
      check({tag, "_flags"}, rsp_flags, v.flags);
      check({tag, "_err"}, rsp_err, v.err);
      check({tag, "_busy"}, {busy, req_ready}, 2'b10);
      hold_bad = 0;
      for (int i = 0; i < v.hold; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_result !== v.res ||
             rsp_flags !== v.flags || rsp_err !== v.err) hold_bad++;
      end
      if (v.hold > 0) check({tag, "_hold_bad"}, hold_bad, 0);
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
      check({tag, "_consumed"}, {rsp_valid, req_ready}, 2'b01);
      check({tag, "_result_kept"}, rsp_result, v.res);
   endtask

   initial begin
      int lat;
      int seen;
      pass_cnt  = 0;
      total_cnt = 0;
      rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
      req_op1 = '0; req_op2 = '0; req_func = '0;
      rst4_n = 1'b0; req_valid4 = 1'b0; rsp_ready4 = 1'b0;
      req_op1_4 = '0; req_op2_4 = '0; req_func4 = '0;

      //                op1           op2           func    res           flags    err  lat hold
      vecs[0]  = '{32'd5,        32'd7,        3'b000, 32'd12,       4'b0000, 1'b0, 2, 0};
      vecs[1]  = '{32'd9,        32'd9,        3'b001, 32'd0,        4'b0101, 1'b0, 2, 0};
      vecs[2]  = '{32'd3,        32'd3,        3'b001, 32'd0,        4'b0101, 1'b0, 2, 0};
      vecs[3]  = '{32'd6,        32'hFFFFFFF9, 3'b010, 32'hFFFFFFD6, 4'b0010, 1'b0, 2, 5};
      vecs[4]  = '{32'h0000F0F0, 32'h0000FF00, 3'b100, 32'h0000F000, 4'b0000, 1'b0, 2, 0};
      vecs[5]  = '{32'd1,        32'd2,        3'b101, 32'd3,        4'b0000, 1'b0, 2, 0};
      vecs[6]  = '{32'hFFFFFFFF, 32'd0,        3'b110, 32'd0,        4'b0001, 1'b0, 2, 0};
      vecs[7]  = '{32'd1,        32'd2,        3'b111, 32'd0,        4'b0000, 1'b1, 1, 0};
      vecs[8]  = '{32'h7FFFFFFF, 32'd1,        3'b000, 32'h80000000, 4'b1010, 1'b0, 2, 0};
`ifdef ALU_ISSUE_DIV0_TRAP_EN
      vecs[9]  = '{32'd10,       32'd0,        3'b011, 32'd0,        4'b1000, 1'b1, 1, 0};
`else
      vecs[9]  = '{32'd10,       32'd0,        3'b011, 32'd0,        4'b1011, 1'b0, 2, 0};
`endif
      vecs[10] = '{32'd100,      32'd7,        3'b011, 32'd14,       4'b0010, 1'b0, 2, 0};

      repeat (2) @(posedge clk);
      #1;
      check("reset_ready_busy", {req_ready, busy}, 2'b10);
      check("reset_alu_func", alu_func, 3'b111);
      check("reset_alu_ops", {alu_op1, alu_op2}, 64'd0);
      check("reset_rsp", {rsp_valid, rsp_err, rsp_flags, rsp_result}, 38'd0);
      @(negedge clk);
      rst_n  = 1'b1;
      rst4_n = 1'b1;

      for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

      // Reset in the middle of EXEC on the SETTLE_CYCLES=4 instance.
      @(negedge clk);
      req_valid4 = 1'b1; req_op1_4 = 32'd2; req_op2_4 = 32'd3; req_func4 = 3'b000;
      @(posedge clk);
      @(negedge clk);
      req_valid4 = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("r4_in_exec", {busy4, alu_func4}, {1'b1, 3'b000});
      rst4_n = 1'b0;
      #1;
      check("r4_async_func", alu_func4, 3'b111);
      check("r4_async_state", {busy4, req_ready4, rsp_valid4}, 3'b010);
      check("r4_async_ops", {alu_op1_4, alu_op2_4}, 64'd0);
      @(negedge clk);
      rst4_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (rsp_valid4 !== 1'b0 || busy4 !== 1'b0) seen++;
      end
      check("r4_no_response", seen, 0);

      // Normal operation afterwards: 20 + 22, latency 1+4 edges.
      req_valid4 = 1'b1; req_op1_4 = 32'd20; req_op2_4 = 32'd22; req_func4 = 3'b000;
      @(posedge clk);
      @(negedge clk);
      req_valid4 = 1'b0;
      lat = 0;
      while (rsp_valid4 !== 1'b1 && lat < 40) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      check("r4_latency", lat, 5);
      check("r4_result", rsp_result4, 32'd42);
      check("r4_flags_err", {rsp_flags4, rsp_err4}, 5'b00000);
      rsp_ready4 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready4 = 1'b0;
      check("r4_consumed", {rsp_valid4, req_ready4}, 2'b01);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
